pin_cmd_responder: RTL and testbench



---
 rtl/pin_cmd_responder_pkg.sv | 36 +++
 rtl/pin_cmd_responder_toggle_sync.sv | 33 +++
 rtl/pin_cmd_responder.sv | 166 ++++++++++++++++
 tb/tb_pin_cmd_responder.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/pin_cmd_responder_pkg.sv
// Shared types and constants for the pin command responder: opcode and
// FSM state encodings, fixed response bytes and command-field helpers.
package pin_cmd_pkg;

  typedef enum logic [1:0] {
    OP_NOP   = 2'b00,
    OP_WRITE = 2'b01,
    OP_READ  = 2'b10,
    OP_CLEAR = 2'b11
  } op_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_WDATA = 1'b1
  } state_e;

  localparam logic [7:0] VERSION  = 8'h5A;
  localparam logic [7:0] BAD_READ = 8'hFF;

  // Opcode lives in the top two bits of a command byte.
  function automatic op_e decode_op(input logic [7:0] cmd);
    return op_e'(cmd[7:6]);
  endfunction

  // Register address lives in the bottom two bits; bits [5:2] are ignored.
  function automatic logic [1:0] decode_addr(input logic [7:0] cmd);
    return cmd[1:0];
  endfunction

  // True when the two-bit address selects an implemented register.
  function automatic logic addr_in_range(input logic [1:0] addr,
                                         input int unsigned nregs);
    return ({30'b0, addr} < nregs);
  endfunction

endpackage

// File: rtl/pin_cmd_responder_toggle_sync.sv
// Strobe synchronizer: brings the host toggle strobe into the clk domain
// through a SYNC_STAGES-deep flop chain and turns each level change into
// a single-cycle pulse by comparing against the previous synchronized value.
module toggle_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic strb_async,
  output logic strb_event
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   strb_q;

  // Synchronizer chain and edge-detect history; strb_q tracks the
  // synchronized strobe every cycle regardless of enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      strb_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], strb_async};
      strb_q <= sync_q[SYNC_STAGES-1];
    end
  end

  // One byte per strobe level change.
  always_comb begin
    strb_event = sync_q[SYNC_STAGES-1] ^ strb_q;
  end

endmodule

// File: rtl/pin_cmd_responder.sv
// Byte-wide command responder behind the dedicated pins. Decodes NOP,
// WRITE (two-byte), READ and CLEAR commands against a small register file
// and answers each completed command with a response byte and an ack toggle.
module pin_cmd_responder
  import pin_cmd_pkg::*;
#(
  parameter int unsigned NREGS       = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ena,
  input  logic [7:0]         pin_data_i,
  input  logic               pin_strb_i,
  output logic [7:0]         pin_data_o,
  output logic               pin_ack_o,
  output logic               pin_err_o,
  output logic [8*NREGS-1:0] regs_o
);

  localparam int unsigned AW = (NREGS > 1) ? $clog2(NREGS) : 1;
  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  logic           strb_event;
  logic           byte_evt;
  op_e            cmd_op;
  logic [1:0]     cmd_addr;
  logic [AW-1:0]  cmd_idx;
  logic [AW-1:0]  wr_idx;
  logic           cmd_ok;
  logic           wr_ok;

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [1:0]     addr_q, addr_d;
  logic [7:0]     data_q, data_d;
  logic           ack_q, ack_d;
  logic           err_q, err_d;
  logic [7:0]     regs_q [NREGS];
  logic [7:0]     regs_d [NREGS];

  toggle_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk        (clk),
    .rst        (rst),
    .strb_async (pin_strb_i),
    .strb_event (strb_event)
  );

  // Command field decode; events are discarded entirely while disabled.
  always_comb begin
    byte_evt = strb_event & ena;
    cmd_op   = decode_op(pin_data_i);
    cmd_addr = decode_addr(pin_data_i);
    cmd_idx  = cmd_addr[AW-1:0];
    wr_idx   = addr_q[AW-1:0];
    cmd_ok   = addr_in_range(cmd_addr, NREGS);
    wr_ok    = addr_in_range(addr_q, NREGS);
  end

  // State, counter, response and register file registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      regs_q  <= '{default: '0};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      regs_q  <= regs_d;
    end
  end

  // Next-state and datapath decisions; everything holds unless a command
  // completes. In WDATA a byte event takes priority over the timeout.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    ack_d   = ack_q;
    err_d   = err_q;
    regs_d  = regs_q;

    case (state_q)
      ST_IDLE: begin
        if (byte_evt) begin
          case (cmd_op)
            OP_NOP: begin
              data_d = VERSION;
              ack_d  = ~ack_q;
            end
            OP_WRITE: begin
              state_d = ST_WDATA;
              cnt_d   = '0;
              addr_d  = cmd_addr;
            end
            OP_READ: begin
              ack_d = ~ack_q;
              if (cmd_ok) begin
                data_d = regs_q[cmd_idx];
              end else begin
                data_d = BAD_READ;
                err_d  = 1'b1;
              end
            end
            OP_CLEAR: begin
              for (int unsigned k = 0; k < NREGS; k++) begin
                regs_d[k] = '0;
              end
              err_d  = 1'b0;
              data_d = '0;
              ack_d  = ~ack_q;
            end
            default: ;
          endcase
        end
      end

      ST_WDATA: begin
        if (byte_evt) begin
          state_d = ST_IDLE;
          ack_d   = ~ack_q;
          data_d  = pin_data_i;
          if (wr_ok) begin
            regs_d[wr_idx] = pin_data_i;
          end else begin
            err_d = 1'b1;
          end
        end else if (ena) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            state_d = ST_IDLE;
            ack_d   = ~ack_q;
            err_d   = 1'b1;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // Drive pins and flatten the register file for the core.
  always_comb begin
    pin_data_o = data_q;
    pin_ack_o  = ack_q;
    pin_err_o  = err_q;
    regs_o     = '0;
    for (int unsigned k = 0; k < NREGS; k++) begin
      regs_o[8*k +: 8] = regs_q[k];
    end
  end

endmodule

// File: tb/tb_pin_cmd_responder.sv
// Bench for pin_cmd_responder: two instances (default parameters, and a
// 2-register / short-timeout variant) driven by directed byte sequences.
module tb_pin_cmd_responder;

  logic        clk = 1'b0;
  logic        rst;

  logic        a_ena, a_strb;
  logic [7:0]  a_din, a_dout;
  logic        a_ack, a_err;
  logic [31:0] a_regs;

  logic        b_ena, b_strb;
  logic [7:0]  b_din, b_dout;
  logic        b_ack, b_err;
  logic [15:0] b_regs;

  always #5 clk = ~clk;

  pin_cmd_responder #(.NREGS(4), .SYNC_STAGES(2), .TIMEOUT(255)) dut_a (
    .clk        (clk),
    .rst        (rst),
    .ena        (a_ena),
    .pin_data_i (a_din),
    .pin_strb_i (a_strb),
    .pin_data_o (a_dout),
    .pin_ack_o  (a_ack),
    .pin_err_o  (a_err),
    .regs_o     (a_regs)
  );

  pin_cmd_responder #(.NREGS(2), .SYNC_STAGES(2), .TIMEOUT(10)) dut_b (
    .clk        (clk),
    .rst        (rst),
    .ena        (b_ena),
    .pin_data_i (b_din),
    .pin_strb_i (b_strb),
    .pin_data_o (b_dout),
    .pin_ack_o  (b_ack),
    .pin_err_o  (b_err),
    .regs_o     (b_regs)
  );

  typedef struct {
    logic [7:0]  data;
    bit          chk_data;
    logic        err;
    logic [31:0] regs;
  } exp_t;

  exp_t        qa[$];
  exp_t        qb[$];
  int unsigned n_total = 0;
  int unsigned n_pass  = 0;
  logic        a_exp_ack = 1'b0;
  logic        b_exp_ack = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Scoreboard monitors: every ack toggle consumes one expected response.
  exp_t ea, eb;
  logic a_prev = 1'b0;
  logic b_prev = 1'b0;

  always @(negedge clk) begin
    if (rst) a_prev <= 1'b0;
    else if (a_ack !== a_prev) begin
      a_prev <= a_ack;
      if (qa.size() == 0) begin
        n_total++;
        $display("FAIL a_unexpected_ack: got toggle to %0b expected none", a_ack);
      end else begin
        ea = qa.pop_front();
        if (ea.chk_data) check("a_data", 32'(a_dout), 32'(ea.data));
        check("a_err", 32'(a_err), 32'(ea.err));
        check("a_regs", a_regs, ea.regs);
      end
    end
  end

  always @(negedge clk) begin
    if (rst) b_prev <= 1'b0;
    else if (b_ack !== b_prev) begin
      b_prev <= b_ack;
      if (qb.size() == 0) begin
        n_total++;
        $display("FAIL b_unexpected_ack: got toggle to %0b expected none", b_ack);
      end else begin
        eb = qb.pop_front();
        if (eb.chk_data) check("b_data", 32'(b_dout), 32'(eb.data));
        check("b_err", 32'(b_err), 32'(eb.err));
        check("b_regs", 32'(b_regs), eb.regs);
      end
    end
  end

  task automatic toggle(input bit sel, input logic [7:0] d);
    @(negedge clk);
    if (sel) begin b_din = d; b_strb = ~b_strb; end
    else     begin a_din = d; a_strb = ~a_strb; end
  endtask

  task automatic push_exp(input bit sel, input logic [7:0] ed, input bit cd,
                          input logic ee, input logic [31:0] er, output logic start);
    exp_t e;
    e.data = ed; e.chk_data = cd; e.err = ee; e.regs = er;
    if (sel) begin start = b_exp_ack; qb.push_back(e); b_exp_ack = ~b_exp_ack; end
    else     begin start = a_exp_ack; qa.push_back(e); a_exp_ack = ~a_exp_ack; end
  endtask

  // Counts edges from the toggle until ack leaves its old level (bounded).
  task automatic wait_ack(input bit sel, input logic start, input int lat, input string name);
    int got = 0;
    for (int c = 1; c <= lat + 4; c++) begin
      @(posedge clk); #1;
      if ((sel ? b_ack : a_ack) !== start) begin got = c; break; end
    end
    check(name, 32'(got), 32'(lat));
  endtask

  task automatic send_resp(input bit sel, input logic [7:0] d, input int lat,
                           input logic [7:0] ed, input bit cd, input logic ee,
                           input logic [31:0] er, input string name);
    logic start;
    push_exp(sel, ed, cd, ee, er, start);
    toggle(sel, d);
    wait_ack(sel, start, lat, name);
  endtask

  task automatic send_noack(input bit sel, input logic [7:0] d, input int ncyc, input string name);
    toggle(sel, d);
    repeat (ncyc) @(posedge clk);
    #1;
    check(name, 32'(sel ? b_ack : a_ack), 32'(sel ? b_exp_ack : a_exp_ack));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    a_ena = 1'b1; a_strb = 1'b0; a_din = '0;
    b_ena = 1'b1; b_strb = 1'b0; b_din = '0;
    repeat (3) @(negedge clk);
    check("rst_a_data", 32'(a_dout), 32'h0);
    check("rst_a_ack",  32'(a_ack),  32'h0);
    check("rst_a_err",  32'(a_err),  32'h0);
    check("rst_a_regs", a_regs,      32'h0);
    check("rst_b_regs", 32'(b_regs), 32'h0);
    rst = 1'b0;

    // Instance A: defaults.
    send_resp(0, 8'h00, 3, 8'h5A, 1, 1'b0, 32'h0000_0000, "a_nop_lat");
    send_noack(0, 8'h42, 6, "a_wcmd_noack");
    send_resp(0, 8'hA5, 3, 8'hA5, 1, 1'b0, 32'h00A5_0000, "a_wdata_lat");
    send_resp(0, 8'h82, 3, 8'hA5, 1, 1'b0, 32'h00A5_0000, "a_read2_lat");
    send_noack(0, 8'h40, 6, "a_wcmd0_noack");
    send_resp(0, 8'h3C, 3, 8'h3C, 1, 1'b0, 32'h00A5_003C, "a_wdata0_lat");
    send_resp(0, 8'h80, 3, 8'h3C, 1, 1'b0, 32'h00A5_003C, "a_read0_lat");
    @(negedge clk); a_ena = 1'b0;
    send_noack(0, 8'hC0, 8, "a_ena0_noack");
    a_ena = 1'b1;
    send_resp(0, 8'h82, 3, 8'hA5, 1, 1'b0, 32'h00A5_003C, "a_ena1_read_lat");
    send_resp(0, 8'hBE, 3, 8'hA5, 1, 1'b0, 32'h00A5_003C, "a_ignored_bits_lat");

    // Instance B: two registers, timeout of 10.
    send_noack(1, 8'h41, 6, "b_wcmd_noack");
    send_resp(1, 8'h99, 3, 8'h99, 1, 1'b0, 32'h9900, "b_wdata_lat");
    send_resp(1, 8'h83, 3, 8'hFF, 1, 1'b1, 32'h9900, "b_badread_lat");
    send_noack(1, 8'h42, 6, "b_badwcmd_noack");
    send_resp(1, 8'h11, 3, 8'h11, 0, 1'b1, 32'h9900, "b_badwdata_lat");
    send_resp(1, 8'hC0, 3, 8'h00, 1, 1'b0, 32'h0000, "b_clear_lat");
    send_resp(1, 8'h41, 13, 8'h00, 0, 1'b1, 32'h0000, "b_timeout_lat");
    send_resp(1, 8'hC0, 3, 8'h00, 1, 1'b0, 32'h0000, "b_clear2_lat");
    send_noack(1, 8'h41, 10, "b_align_cmd_noack");
    send_resp(1, 8'h6E, 3, 8'h6E, 1, 1'b0, 32'h6E00, "b_align_data_lat");
    send_noack(1, 8'h40, 6, "b_hold_cmd_noack");
    @(negedge clk); b_ena = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("b_hold_noack", 32'(b_ack), 32'(b_exp_ack));
    b_ena = 1'b1;
    send_resp(1, 8'h2B, 3, 8'h2B, 1, 1'b0, 32'h6E2B, "b_hold_data_lat");
    send_resp(1, 8'h80, 3, 8'h2B, 1, 1'b0, 32'h6E2B, "b_read0_lat");

    // Reset in the middle of a WRITE, with A's strobe high across release.
    send_noack(0, 8'h41, 6, "a_pre_rst_noack");
    @(negedge clk);
    rst = 1'b1; a_din = 8'h00; a_strb = 1'b1; b_strb = 1'b0;
    a_exp_ack = 1'b0; b_exp_ack = 1'b0;
    #1;
    check("mid_rst_a_data", 32'(a_dout), 32'h0);
    check("mid_rst_a_ack",  32'(a_ack),  32'h0);
    check("mid_rst_a_err",  32'(a_err),  32'h0);
    check("mid_rst_a_regs", a_regs,      32'h0);
    check("mid_rst_b_regs", 32'(b_regs), 32'h0);
    check("mid_rst_b_ack",  32'(b_ack),  32'h0);
    begin
      logic s;
      push_exp(0, 8'h5A, 1, 1'b0, 32'h0, s);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      wait_ack(0, s, 3, "a_strb_high_release_lat");
    end
    send_noack(0, 8'h43, 6, "a_post_rst_wcmd_noack");
    send_resp(0, 8'h77, 3, 8'h77, 1, 1'b0, 32'h7700_0000, "a_post_rst_wdata_lat");

    repeat (4) @(negedge clk);
    check("qa_drained", 32'(qa.size()), 32'h0);
    check("qb_drained", 32'(qb.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
